alu_operand_stage: RTL
======================

# alu_operand_stage

Operand-fetch/issue stage directly upstream of the ALU. Holds the architectural register file and decodes R-type funct codes into the ALU's 3-bit function select. It also reads and bypasses both source operands, and presents a registered, handshaked {a, b, f} bundle to the ALU. Results return through a write-back port that updates the register file.

## Interface
- BW_DATA, 32, operand/register width
- BW_ADDR, 5, register address width; file depth 2^BW_ADDR
- i_clk  input  1  clock, all state on rising edge
- i_rstn  input  1  asynchronous, active-low reset
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  stage can accept an instruction this cycle
- i_funct  input  6  R-type funct field
- i_rs  input  BW_ADDR  source register A address
- i_rt  input  BW_ADDR  source register B address
- i_rd  input  BW_ADDR  destination register address
- i_wb_en  input  1  write-back enable
- i_wb_addr  input  BW_ADDR  write-back register address
- i_wb_data  input  BW_DATA  write-back data
- o_valid  output  1  issued bundle valid to ALU
- i_ready  input  1  ALU side accepts bundle
- o_a  output  BW_DATA  operand A (ALU i_a)
- o_b  output  BW_DATA  operand B (ALU i_b)
- o_f  output  3  ALU function select (ALU i_f)
- o_rd  output  BW_ADDR  destination tag travelling with bundle
- o_illegal  output  1  funct not supported

## Operation
- Register file: 2^BW_ADDR x BW_DATA, all entries cleared on reset. Write on clock edge when i_wb_en=1 and i_wb_addr!=0. Entry 0 always reads 0; writes to it are ignored.
- Read with bypass: operand = i_wb_data if i_wb_en, i_wb_addr==addr and addr!=0. Otherwise operand = file[addr]. Applies independently to rs and rt.
- Decode, funct -> o_f:
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 101010 slt -> 111
  - Any other funct -> o_f=010, o_illegal=1, o_rd=0 (write-back suppressed downstream).
- Handshake:
  - accept = i_valid & o_ready.
  - o_ready = ~o_valid | i_ready, combinational.
  - On accept, load o_a, o_b, o_f, o_rd, o_illegal, the latched rs/rt, and set o_valid=1.
  - If o_valid & i_ready & ~accept, clear o_valid.
- Stall refresh: while o_valid=1 and i_ready=0, a write-back with nonzero i_wb_addr equal to the latched rs (rt) overwrites o_a (o_b) with i_wb_data on that edge. Both operands update if rs==rt.
- Outputs are otherwise stable while stalled; i_funct/i_rs/i_rt/i_rd are don't-care when not accepted.
- Write-back is never blocked by stalls; it always commits.

## Timing
- Reset (i_rstn=0, asynchronous): o_valid=0, o_a=0, o_b=0, o_f=000, o_rd=0, o_illegal=0, register file all 0. o_ready=1 immediately.
- Latency: bundle appears on outputs the cycle after accept. Sustained throughput is 1 per cycle when i_ready=1.
- Same-cycle write-back and accept on a matching address: the issued operand is i_wb_data, and the file also holds i_wb_data after the edge.
- Same-cycle write-back, stall and new accept: impossible, since o_ready=0 while stalled.
- Back-to-back dependency (instr N writes rd, N+1 reads rd): correct only via write-back bypass or refresh. The stage does no scoreboarding.
- Reset mid-transfer: held bundle discarded, no partial output; first post-reset accept is a normal issue.
- Address 0 never bypasses or refreshes, even with i_wb_en=1 and nonzero data.

## Test plan
- Reset then wb r1=5, r2=3; issue add rs=1 rt=2 rd=4 -> next cycle o_valid=1, o_a=5, o_b=3, o_f=010, o_rd=4, o_illegal=0.
- Same cycle as issue sub rs=1 rt=2, assert wb r1=0xFFFFFFFF -> o_a=0xFFFFFFFF, o_f=110. A later read of r1 also returns 0xFFFFFFFF.
- Issue or rs=1 rt=1 with i_ready=0 for 3 cycles; wb r1=0xA5 in cycle 2 -> o_a=o_b=0xA5 from cycle 3. o_ready=0 throughout; bundle is consumed when i_ready rises.
- wb r0=0x1234 then issue and rs=0 rt=0 -> o_a=o_b=0, o_f=000.
- Issue funct=000000 -> o_illegal=1, o_f=010, o_rd=0. Next legal slt issue -> o_f=111, o_illegal=0.
- Stream 4 issues with i_ready=1 -> 4 consecutive o_valid cycles. Assert i_rstn=0 mid-stream (asynchronous, between edges) -> o_valid=0 immediately and register file reads 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch/issue stage feeding the ALU.
// Holds the register file, decodes R-type funct into the ALU select,
// reads both sources with write-back bypass, and issues a registered
// {a, b, f, rd, illegal} bundle under a valid/ready handshake.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_valid/o_ready               upstream instruction handshake
//   i_funct, i_rs, i_rt, i_rd     instruction fields
//   i_wb_en/i_wb_addr/i_wb_data   write-back port into the register file
//   o_valid/i_ready               downstream (ALU) handshake
//   o_a, o_b, o_f, o_rd, o_illegal issued bundle
module alu_operand_stage #(
    parameter int unsigned BW_DATA = 32,
    parameter int unsigned BW_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [5:0]         i_funct,
    input  logic [BW_ADDR-1:0] i_rs,
    input  logic [BW_ADDR-1:0] i_rt,
    input  logic [BW_ADDR-1:0] i_rd,
    input  logic               i_wb_en,
    input  logic [BW_ADDR-1:0] i_wb_addr,
    input  logic [BW_DATA-1:0] i_wb_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_a,
    output logic [BW_DATA-1:0] o_b,
    output logic [2:0]         o_f,
    output logic [BW_ADDR-1:0] o_rd,
    output logic               o_illegal
);

    localparam int unsigned DEPTH = 1 << BW_ADDR;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [BW_DATA-1:0] r_file [DEPTH];
    logic               r_valid;
    logic [BW_DATA-1:0] r_a;
    logic [BW_DATA-1:0] r_b;
    logic [2:0]         r_f;
    logic [BW_ADDR-1:0] r_rd;
    logic               r_illegal;
    logic [BW_ADDR-1:0] r_rs;
    logic [BW_ADDR-1:0] r_rt;

    logic               w_accept;
    logic               w_wb_live;
    logic [BW_DATA-1:0] w_op_a;
    logic [BW_DATA-1:0] w_op_b;
    logic [2:0]         w_f;
    logic               w_illegal;

    // Write-back targeting r0 is a no-op everywhere (file, bypass, refresh).
    assign w_wb_live = i_wb_en && (i_wb_addr != '0);

    assign o_ready  = ~r_valid | i_ready;
    assign w_accept = i_valid & o_ready;

    // Source reads with same-cycle write-back bypass.
    assign w_op_a = (w_wb_live && (i_wb_addr == i_rs)) ? i_wb_data : r_file[i_rs];
    assign w_op_b = (w_wb_live && (i_wb_addr == i_rt)) ? i_wb_data : r_file[i_rt];

    // Funct decode; unsupported codes fall back to add and flag illegal.
    always_comb begin
        w_f       = ALU_ADD;
        w_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  w_f = ALU_ADD;
            FN_SUB:  w_f = ALU_SUB;
            FN_AND:  w_f = ALU_AND;
            FN_OR:   w_f = ALU_OR;
            FN_SLT:  w_f = ALU_SLT;
            default: w_illegal = 1'b1;
        endcase
    end

    // Register file; entry 0 is never written so it always reads zero.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_file[i] <= '0;
            end
        end else if (w_wb_live) begin
            r_file[i_wb_addr] <= i_wb_data;
        end
    end

    // Issue register: load on accept, refresh operands while stalled.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_f       <= ALU_AND;
            r_rd      <= '0;
            r_illegal <= 1'b0;
            r_rs      <= '0;
            r_rt      <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_a       <= w_op_a;
            r_b       <= w_op_b;
            r_f       <= w_f;
            r_rd      <= w_illegal ? '0 : i_rd;
            r_illegal <= w_illegal;
            r_rs      <= i_rs;
            r_rt      <= i_rt;
        end else if (r_valid && !i_ready) begin
            if (w_wb_live && (i_wb_addr == r_rs)) begin
                r_a <= i_wb_data;
            end
            if (w_wb_live && (i_wb_addr == r_rt)) begin
                r_b <= i_wb_data;
            end
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_a       = r_a;
    assign o_b       = r_b;
    assign o_f       = r_f;
    assign o_rd      = r_rd;
    assign o_illegal = r_illegal;

endmodule
